// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder step per clock, LSB first, built from two
// half-adder stages and a registered carry. Result and carry are held until the next DONE.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic [WIDTH-1:0] sum_sr_d;
    logic             carry_q;
    logic             carry_d;
    logic [CntW-1:0]  cnt_q;
    logic             s1;
    logic             c1;
    logic             c2;
    logic             bit_sum;

    always_comb begin
        s1       = a_q[0] ^ b_q[0];
        c1       = a_q[0] & b_q[0];
        bit_sum  = s1 ^ carry_q;
        c2       = s1 & carry_q;
        carry_d  = c1 | c2;
        // New bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
        sum_sr_d = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1] = bit_sum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_sum    <= '0;
            o_carry  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        o_busy  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        o_sum   <= sum_sr_d;
                        o_carry <= carry_d;
                        o_done  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1; expected results come from
// plain integer addition and the start edge recorded when each start is issued.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] sum8;
    logic       busy8, done8, carry8;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic [0:0] sum1;
    logic       busy1, done1, carry1;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start8),
        .i_a     (a8),
        .i_b     (b8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8),
        .o_carry (carry8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_carry (carry1)
    );

    typedef struct {
        logic [8:0] res;
        int         start_edge;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitors: an add accepted at edge S keeps busy high through edge S+W and shows done
    // (with its result) only after edge S+W; the result is held at all other times.
    logic [8:0] last8 = '0;
    logic [8:0] last1 = '0;
    logic       xb8, xd8, xb1, xd1;
    exp_t       e8, e1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last8 = '0;
        end else begin
            xb8 = (q8.size() > 0) && (cyc >= q8[0].start_edge) && (cyc <= q8[0].start_edge + 8);
            xd8 = (q8.size() > 0) && (cyc == q8[0].start_edge + 8);
            check("busy8", 64'(busy8), 64'(xb8));
            check("done8", 64'(done8), 64'(xd8));
            if (xd8) begin
                e8 = q8.pop_front();
                last8 = e8.res;
            end
            check("result8", 64'({carry8, sum8}), 64'(last8));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last1 = '0;
        end else begin
            xb1 = (q1.size() > 0) && (cyc >= q1[0].start_edge) && (cyc <= q1[0].start_edge + 1);
            xd1 = (q1.size() > 0) && (cyc == q1[0].start_edge + 1);
            check("busy1", 64'(busy1), 64'(xb1));
            check("done1", 64'(done1), 64'(xd1));
            if (xd1) begin
                e1 = q1.pop_front();
                last1 = e1.res;
            end
            check("result1", 64'({carry1, sum1}), 64'(last1));
        end
    end

    task automatic add8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back('{res: 9'(a) + 9'(b), start_edge: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic add1(input logic [0:0] a, input logic [0:0] b);
        @(negedge clk);
        a1 = a;
        b1 = b;
        start1 = 1'b1;
        q1.push_back('{res: 9'(a) + 9'(b), start_edge: cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy8", 64'(busy8), 64'(0));
        check("rst_done8", 64'(done8), 64'(0));
        check("rst_sum8", 64'(sum8), 64'(0));
        check("rst_carry8", 64'(carry8), 64'(0));
        check("rst_busy1", 64'(busy1), 64'(0));
        check("rst_done1", 64'(done1), 64'(0));
        check("rst_res1", 64'({carry1, sum1}), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        add8(8'h00, 8'h00);
        drain();
        add8(8'hFF, 8'h01);
        drain();
        add8(8'hA5, 8'h5A);
        drain();

        // Extra starts during RUN and DONE must be ignored; operands change mid-run.
        @(negedge clk);
        a8 = 8'h3C;
        b8 = 8'h0F;
        start8 = 1'b1;
        q8.push_back('{res: 9'h04B, start_edge: cyc + 1});
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start8 = (k == 2) || (k == 8);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        start8 = 1'b0;
        drain();

        // Reset mid-run aborts without a done and clears the held result.
        add8(8'h80, 8'h80);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort_busy8", 64'(busy8), 64'(0));
        check("abort_done8", 64'(done8), 64'(0));
        check("abort_sum8", 64'(sum8), 64'(0));
        check("abort_carry8", 64'(carry8), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        add8(8'h01, 8'h02);
        drain();

        // Start held high: accepted at edges S, S+10, S+20.
        @(negedge clk);
        a8 = 8'h7F;
        b8 = 8'h7F;
        start8 = 1'b1;
        for (int k = 0; k < 3; k++) q8.push_back('{res: 9'h0FE, start_edge: cyc + 1 + 10 * k});
        repeat (21) @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        drain();

        for (int n = 0; n < 20; n++) begin
            add8(8'($urandom), 8'($urandom));
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        add1(1'b0, 1'b0);
        drain();
        add1(1'b0, 1'b1);
        drain();
        add1(1'b1, 1'b0);
        drain();
        add1(1'b1, 1'b1);
        drain();
        for (int n = 0; n < 8; n++) begin
            add1(1'($urandom), 1'($urandom));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
